// File: rtl/gen_regfile.sv
// Parametrised multi-port register file with write-to-read bypass and a
// per-register pending-write scoreboard for the pipeline hazard unit.
module gen_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int PEND_W   = 2,
    parameter int TRACE    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_WR*32-1:0]       wr_pc,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       iss_stall,
    output logic                       err_ovf,
    output logic                       err_unf
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [DATA_W-1:0] mem_d  [DEPTH];
    logic [PEND_W-1:0] pend_q [DEPTH];
    logic [PEND_W-1:0] pend_d [DEPTH];
    logic              err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;
    logic [ADDR_W-1:0] wa_s [NUM_WR];
    logic [DATA_W-1:0] wd_s [NUM_WR];
    logic [NUM_WR-1:0] wr_ok_s;
    logic [NUM_WR-1:0] commit_s;

    // Writes to register 0 (when hard-wired) and writes under reset never happen.
    always_comb begin
        wr_ok_s = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wa_s[p]    = wr_addr[p*ADDR_W +: ADDR_W];
            wd_s[p]    = wr_data[p*DATA_W +: DATA_W];
            wr_ok_s[p] = reset && wr_en[p] && !((ZERO_REG != 0) && (wa_s[p] == '0));
        end
    end

    // A write commits only if no higher-index port targets the same register.
    always_comb begin
        commit_s = wr_ok_s;
        for (int p = 0; p < NUM_WR; p++) begin
            for (int q = p + 1; q < NUM_WR; q++) begin
                if (wr_ok_s[q] && (wa_s[q] == wa_s[p])) begin
                    commit_s[p] = 1'b0;
                end else begin
                    commit_s[p] = commit_s[p];
                end
            end
        end
    end

    assign iss_stall = iss_en && (pend_q[iss_addr] == PEND_MAX);

    // Combinational read ports: stored value, optional bypass, busy from effective count.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdv;
        int                ret;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra  = rd_addr[k*ADDR_W +: ADDR_W];
            rdv = mem_q[ra];
            ret = 0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_ok_s[p] && (wa_s[p] == ra)) begin
                    ret = ret + 1;
                    if (BYPASS != 0) begin
                        rdv = wd_s[p];
                    end else begin
                        rdv = rdv;
                    end
                end else begin
                    ret = ret;
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rdv = '0;
            end else begin
                rdv = rdv;
            end
            rd_data[k*DATA_W +: DATA_W] = rdv;
            if (BYPASS != 0) begin
                rd_busy[k] = int'(pend_q[ra]) > ret;
            end else begin
                rd_busy[k] = pend_q[ra] != '0;
            end
        end
    end

    // Next-state for storage, scoreboard counters and sticky error flags.
    always_comb begin
        logic inc;
        int   cnt;
        mem_d     = mem_q;
        pend_d    = pend_q;
        err_ovf_d = err_ovf_q | (reset && iss_stall);
        err_unf_d = err_unf_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (commit_s[p]) begin
                mem_d[wa_s[p]] = wd_s[p];
            end else begin
                mem_d[wa_s[p]] = mem_d[wa_s[p]];
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            inc = iss_en && !iss_stall && (iss_addr == ADDR_W'(a))
                  && !((ZERO_REG != 0) && (a == 0));
            cnt = int'(pend_q[a]) + (inc ? 1 : 0);
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_ok_s[p] && (wa_s[p] == ADDR_W'(a))) begin
                    cnt = cnt - 1;
                end else begin
                    cnt = cnt;
                end
            end
            if (cnt < 0) begin
                pend_d[a] = '0;
                err_unf_d = 1'b1;
            end else begin
                pend_d[a] = PEND_W'(cnt);
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q     <= '{default: '0};
            pend_q    <= '{default: '0};
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            pend_q    <= pend_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;

    if (TRACE != 0) begin : g_trace
        // Simulation trace of committed writes, lowest port first.
        always @(posedge clk) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (commit_s[p]) begin
                    $display("@%h: $%d <= %h", wr_pc[p*32 +: 32], wa_s[p], wd_s[p]);
                end
            end
        end
    end else begin : g_no_trace
        logic unused_pc_s;
        assign unused_pc_s = ^wr_pc;
    end

endmodule

// File: tb/tb_gen_regfile.sv
// Self-checking bench for gen_regfile: directed scenarios then random traffic,
// checked against an array-based reference model (bypass and non-bypass DUTs).
module tb_gen_regfile;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data_b, rd_data_n;
    logic [NR-1:0]     busy_b, busy_n;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NW*32-1:0]  wr_pc;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              stall_b, stall_n, ovf_b, ovf_n, unf_b, unf_n;

    gen_regfile #(.BYPASS(1), .TRACE(1)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(stall_b),
        .err_ovf(ovf_b), .err_unf(unf_b));

    gen_regfile #(.BYPASS(0), .TRACE(0)) dut_n (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(stall_n),
        .err_ovf(ovf_n), .err_unf(unf_n));

    always #5 clk = ~clk;

    logic [31:0] reg_m [32];
    int          pend_m [32];
    bit          ovf_m, unf_m;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 32; a++) begin
            reg_m[a]  = 32'd0;
            pend_m[a] = 0;
        end
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    function automatic int retires(input int a);
        int n = 0;
        if (a == 0) return 0;
        for (int p = 0; p < NW; p++)
            if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) n++;
        return n;
    endfunction

    function automatic logic [31:0] exp_rd(input int a, input bit byp);
        logic [31:0] v;
        if (a == 0) return 32'd0;
        v = reg_m[a];
        if (byp)
            for (int p = 0; p < NW; p++)
                if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) v = wr_data[p*DW +: DW];
        return v;
    endfunction

    function automatic bit exp_busy(input int a, input bit byp);
        if (byp) return (pend_m[a] - retires(a)) > 0;
        return pend_m[a] != 0;
    endfunction

    function automatic bit exp_stall();
        return iss_en && pend_m[int'(iss_addr)] == 3;
    endfunction

    task automatic check_all();
        int a;
        for (int k = 0; k < NR; k++) begin
            a = int'(rd_addr[k*AW +: AW]);
            check($sformatf("rd_data_byp%0d", k), rd_data_b[k*DW +: DW], exp_rd(a, 1'b1));
            check($sformatf("rd_data_nob%0d", k), rd_data_n[k*DW +: DW], exp_rd(a, 1'b0));
            check($sformatf("rd_busy_byp%0d", k), 32'(busy_b[k]), 32'(exp_busy(a, 1'b1)));
            check($sformatf("rd_busy_nob%0d", k), 32'(busy_n[k]), 32'(exp_busy(a, 1'b0)));
        end
        check("iss_stall", 32'({stall_b, stall_n}), 32'({2{exp_stall()}}));
        check("err_ovf", 32'({ovf_b, ovf_n}), 32'({2{ovf_m}}));
        check("err_unf", 32'({unf_b, unf_n}), 32'({2{unf_m}}));
    endtask

    // Spec-level update at a rising edge: counters move by issues minus retires.
    task automatic model_edge();
        int  newp [32];
        bit  st;
        if (!reset) begin
            model_reset();
            return;
        end
        st = exp_stall();
        for (int a = 0; a < 32; a++) begin
            newp[a] = pend_m[a] - retires(a);
            if (a != 0 && iss_en && int'(iss_addr) == a && !st) newp[a]++;
            if (newp[a] < 0) begin
                newp[a] = 0;
                unf_m = 1'b1;
            end
        end
        for (int p = 0; p < NW; p++)
            if (wr_en[p] && wr_addr[p*AW +: AW] != 5'd0)
                reg_m[int'(wr_addr[p*AW +: AW])] = wr_data[p*DW +: DW];
        for (int a = 0; a < 32; a++) pend_m[a] = newp[a];
        if (st) ovf_m = 1'b1;
    endtask

    task automatic step();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en  = 2'b00;
        iss_en = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wr_en[p]             = 1'b1;
        wr_addr[p*AW +: AW]  = 5'(a);
        wr_data[p*DW +: DW]  = d;
        wr_pc[p*32 +: 32]    = 32'h0000_3000 + 32'(p * 4);
    endtask

    task automatic issue(input int a);
        iss_en   = 1'b1;
        iss_addr = 5'(a);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_pc    = '0;
        iss_addr = '0;
        idle();
        model_reset();
        @(negedge clk);
        #1 check_all();
        @(negedge clk);
        reset = 1'b1;

        // Asynchronous reset clears storage and sticky flags mid-cycle.
        rd_addr = {5'd0, 5'd3};
        wr(0, 3, 32'h1234_5678);
        step();
        idle();
        #1 check("pre_reset_rd3", rd_data_b[31:0], 32'h1234_5678);
        check("pre_reset_unf", 32'(unf_b), 32'd1);
        #1 reset = 1'b0;
        model_reset();
        #1 check("async_rd3", rd_data_b[31:0], 32'd0);
        check("async_errs", 32'({ovf_b, unf_b}), 32'd0);
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Dual write to the same register: port 1 wins, both retire.
        issue(5); step(); step(); idle();
        wr(0, 5, 32'h0000_AAAA);
        wr(1, 5, 32'h0000_BBBB);
        rd_addr = {5'd5, 5'd5};
        step();
        idle();
        #1 check("dual_rd5", rd_data_n[31:0], 32'h0000_BBBB);
        check("dual_busy5", 32'({busy_b[0], busy_n[0], unf_b}), 32'd0);
        step();

        // Same-cycle bypass versus registered read.
        rd_addr = {5'd5, 5'd7};
        wr(0, 7, 32'h0000_DEAD);
        #1 check("byp_same_cycle", rd_data_b[31:0], 32'h0000_DEAD);
        check("nobyp_old_value", rd_data_n[31:0], 32'd0);
        step();
        idle();
        #1 check("nobyp_next_cycle", rd_data_n[31:0], 32'h0000_DEAD);
        step();

        // Register 0 ignores writes and issues.
        rd_addr = {5'd0, 5'd0};
        wr(0, 0, 32'h0000_FFFF);
        issue(0);
        #1 check("zero_rd_byp", rd_data_b[31:0], 32'd0);
        check("zero_busy_stall", 32'({busy_b, busy_n, stall_b}), 32'd0);
        step();
        idle();
        step();

        // Scoreboard saturation and retire sequence on $9.
        rd_addr = {5'd0, 5'd9};
        issue(9); step(); step(); step();
        #1 check("sat_stall", 32'({stall_b, stall_n}), 32'd3);
        step();
        idle();
        #1 check("sat_ovf", 32'(ovf_b), 32'd1);
        check("sat_busy", 32'(busy_b[0]), 32'd1);
        wr(0, 9, 32'h0000_0901);
        step();
        idle();
        issue(9);
        wr(1, 9, 32'h0000_0902);
        #1 check("iss_ret_nostall", 32'(stall_b), 32'd0);
        step();
        idle();
        wr(0, 9, 32'h0000_0903);
        #1 check("busy_mid", 32'(busy_b[0]), 32'd1);
        step();
        idle();
        wr(0, 9, 32'h0000_0904);
        #1 check("busy_last_byp", 32'(busy_b[0]), 32'd0);
        check("busy_last_nob", 32'(busy_n[0]), 32'd1);
        step();
        idle();
        #1 check("busy_clear", 32'({busy_b[0], busy_n[0]}), 32'd0);
        step();

        // Underflow: write with nothing pending.
        do_reset();
        rd_addr = {5'd0, 5'd4};
        wr(0, 4, 32'h0000_0077);
        step();
        idle();
        #1 check("unf_set", 32'({unf_b, unf_n}), 32'd3);
        check("unf_data", rd_data_n[31:0], 32'h0000_0077);
        step(); step();
        #1 check("unf_sticky", 32'(unf_b), 32'd1);

        // Random traffic on a narrow address range to force collisions.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rd_addr  = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            wr_en    = 2'($urandom_range(0, 3));
            wr_addr  = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            wr_data  = {32'($urandom), 32'($urandom)};
            wr_pc    = {32'($urandom), 32'($urandom)};
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = 5'($urandom_range(0, 15));
            step();
        end
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gen_regfile.md
Name: gen_regfile

Overview:
- Parametrised general-purpose register file, successor to the single-write GRF, for the pipelined CPU (P6/P7).
- Adds configurable data width, depth, read-port count and write-port count, plus optional write-to-read bypass.
- Adds a per-register pending-write scoreboard, so the hazard unit can query "value not yet produced" directly from the register file.
- Keeps the "@pc: $reg <= data" write trace.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports; higher index has higher priority
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads
- ZERO_REG, 1, 1 = register 0 reads as 0 and is never written or tracked
- PEND_W, 2, width of each per-register pending counter
- TRACE, 1, 1 = $display a trace line for each committed write

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  read register still has an outstanding write
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- wr_pc  in  NUM_WR*32  instruction PC per write port (trace only)
- iss_en  in  1  issue of an instruction that will write iss_addr
- iss_addr  in  ADDR_W  destination of the issuing instruction
- iss_stall  out  1  pending[iss_addr] is saturated; issue is refused
- err_ovf  out  1  sticky: an issue was attempted while saturated
- err_unf  out  1  sticky: a write retired against a zero counter

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers, pending counters, err_ovf and err_unf clear to 0 immediately.
  - rd_data then reads 0, rd_busy=0, iss_stall=0.
  - Writes and issues are ignored while reset is held. Deassertion takes effect at the next clk edge.
- Writes:
  - Registers update at posedge clk. Write latency is 1 cycle.
  - If several write ports target the same address in one cycle, the highest-index enabled port wins. Lower-index writes to that address are dropped and not traced.
  - With ZERO_REG=1, writes to address 0 are discarded: no trace, no scoreboard effect.
- Reads:
  - Read ports are purely combinational.
  - BYPASS=1: if any enabled write port matches rd_addr[k] (and the address is not 0 with ZERO_REG=1), rd_data[k] = wr_data of the highest-index matching port. Otherwise rd_data[k] is the stored value.
  - BYPASS=0: reads always return the stored value; new data is visible the cycle after the write.
- Scoreboard: one PEND_W-bit counter per register, address 0 excluded when ZERO_REG=1.
  - Each posedge: pending[a] += (iss_en && iss_addr==a && !iss_stall) - (number of enabled write ports with wr_addr==a).
  - Each write port retires once. Duplicate ports to the same address retire separately, even though only one commits data.
  - Simultaneous issue and one retire to the same address leave the counter unchanged.
  - The counter clamps at 0. Any attempted decrement below 0 sets err_unf.
- iss_stall = iss_en && pending[iss_addr] == 2**PEND_W-1.
  - While stalled, the issue is ignored. err_ovf is set at that edge.
  - err_ovf and err_unf stay set until reset.
- rd_busy[k] = (pending[rd_addr[k]] minus this cycle's retires to rd_addr[k], floored at 0) != 0.
  - This uses the effective count when BYPASS=1. With BYPASS=0, the raw pending value is used.
  - rd_busy for address 0 is always 0 when ZERO_REG=1.
- Trace (TRACE=1): at each committed write, $display("@%h: $%d <= %h", wr_pc, addr, data), in ascending port index order.

Test Plan:
- Async reset: write 0x12345678 to $3, then pull reset low mid-cycle → rd_data for $3 = 0 before the next edge; err flags = 0.
- Dual-write conflict: port0 writes $5=0xAAAA and port1 writes $5=0xBBBB in the same cycle → $5=0xBBBB next cycle; only one trace line, showing port1's wr_pc; pending[5] decremented twice.
- Bypass: BYPASS=1, write $7=0xDEAD while rd_addr0=$7 → rd_data0=0xDEAD in the same cycle. With BYPASS=0 it returns the old value until the next cycle.
- Zero register: write $0=0xFFFF and issue to $0 → rd_data=0, rd_busy=0, no trace line, pending unchanged.
- Scoreboard saturation (PEND_W=2): issue $9 four times → counter=3, 4th issue raises iss_stall and sets err_ovf. One retire brings the counter to 2. A simultaneous issue+retire keeps it at 2. rd_busy for $9 stays high until the last retire.
- Underflow: write $4 with pending[4]=0 → data commits, counter stays 0, err_unf=1 and stays set until reset.
